// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: single-outstanding fetch controller for a slow async ROM.
// Accepts one address, holds ce_n/oe_n low for ACCESS_CYCLES edges, returns the word.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid/req_ready  fetch request handshake, req_addr is the fetch address
//   rsp_valid/rsp_ready  response handshake, rsp_data is the fetched word
//   flush                abort any in-flight or pending fetch
//   busy                 high whenever the controller is not idle
//   ce_n, oe_n, rom_addr registered ROM controls
//   rom_dout             ROM data, sampled ACCESS_CYCLES edges after ce_n falls
module rom_fetch_ctrl #(
    parameter int ACCESS_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    input  logic        rsp_ready,
    input  logic        flush,
    output logic        busy,
    output logic        ce_n,
    output logic        oe_n,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_dout
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        ce_nx, oe_nx;
    logic [15:0] addr_nx;
    logic        vld_nx;
    logic [15:0] data_nx;
    logic        accept;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid & req_ready & ~flush;

    // State register plus the registered ROM/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ce_n      <= 1'b1;
            oe_n      <= 1'b1;
            rom_addr  <= 16'h0000;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ce_n      <= ce_nx;
            oe_n      <= oe_nx;
            rom_addr  <= addr_nx;
            rsp_valid <= vld_nx;
            rsp_data  <= data_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nx = ACCESS;
            end
            ACCESS: begin
                // flush wins even on the capture edge
                if (flush)
                    state_nx = IDLE;
                else if (cnt == LAST)
                    state_nx = RESP;
            end
            RESP: begin
                if (flush || rsp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        cnt_nx  = cnt;
        ce_nx   = ce_n;
        oe_nx   = oe_n;
        addr_nx = rom_addr;
        vld_nx  = rsp_valid;
        data_nx = rsp_data;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    addr_nx = req_addr;
                    ce_nx   = 1'b0;
                    oe_nx   = 1'b0;
                    cnt_nx  = 4'd1;
                end
            end
            ACCESS: begin
                if (flush) begin
                    ce_nx  = 1'b1;
                    oe_nx  = 1'b1;
                    cnt_nx = 4'd0;
                end else if (cnt == LAST) begin
                    data_nx = rom_dout;
                    vld_nx  = 1'b1;
                    ce_nx   = 1'b1;
                    oe_nx   = 1'b1;
                    cnt_nx  = 4'd0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            RESP: begin
                // rsp_data is left alone; only rsp_valid qualifies it
                if (flush || rsp_ready)
                    vld_nx = 1'b0;
            end
            default: begin
                ce_nx  = 1'b1;
                oe_nx  = 1'b1;
                cnt_nx = 4'd0;
                vld_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb_rom_fetch_ctrl: directed bench for rom_fetch_ctrl with a slow-ROM model.
// Checks reset, fetch latency, back-pressure, back-to-back, flush and async reset.
module tb_rom_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_ready;
    logic        flush;
    logic        busy;
    logic        ce_n;
    logic        oe_n;
    logic [15:0] rom_addr;
    logic [15:0] rom_dout;

    int n_vec = 0;
    int n_err = 0;

    rom_fetch_ctrl #(.ACCESS_CYCLES(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .flush     (flush),
        .busy      (busy),
        .ce_n      (ce_n),
        .oe_n      (oe_n),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: 0x0010 holds BEEF, everything else holds addr+1.
    function automatic logic [15:0] rom_word(input logic [15:0] a);
        if (a == 16'h0010)
            return 16'hBEEF;
        return a + 16'h0001;
    endfunction

    // Slow ROM: data appears on the 5th edge sampling ce_n=oe_n=0,
    // garbage (DEAD) otherwise; counter clears when either is seen high.
    logic [3:0] rcnt;
    always @(posedge clk) begin
        if (ce_n || oe_n) begin
            rcnt     <= 4'd0;
            rom_dout <= 16'hDEAD;
        end else begin
            if (rcnt != 4'd15)
                rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd4)
                rom_dout <= rom_word(rom_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 ns after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        #12;
        chk("rst_ce_n", ce_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_addr", rom_addr, 16'h0000);
        chk("rst_vld", rsp_valid, 0);
        chk("rst_data", rsp_data, 16'h0000);
        chk("rst_rdy", req_ready, 1);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Single fetch of 0x0010
        req_valid = 1'b1;
        req_addr  = 16'h0010;
        step();
        req_valid = 1'b0;
        req_addr  = 16'h5555;
        chk("e0_ce_n", ce_n, 0);
        chk("e0_oe_n", oe_n, 0);
        chk("e0_addr", rom_addr, 16'h0010);
        chk("e0_busy", busy, 1);
        chk("e0_rdy", req_ready, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("acc%0d_vld", i), rsp_valid, 0);
            chk($sformatf("acc%0d_ce_n", i), ce_n, 0);
            chk($sformatf("acc%0d_addr", i), rom_addr, 16'h0010);
        end
        step();
        chk("e6_vld", rsp_valid, 1);
        chk("e6_data", rsp_data, 16'hBEEF);
        chk("e6_ce_n", ce_n, 1);
        chk("e6_oe_n", oe_n, 1);

        // Back-pressure
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_vld", rsp_valid, 1);
            chk("bp_data", rsp_data, 16'hBEEF);
            chk("bp_ce_n", ce_n, 1);
            chk("bp_rdy", req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_rel_vld", rsp_valid, 0);
        chk("bp_rel_busy", busy, 0);
        chk("bp_rel_rdy", req_ready, 1);
        chk("bp_rel_data", rsp_data, 16'hBEEF);

        // Back-to-back: 0x0000 then 0x0001 held pending
        req_valid = 1'b1;
        req_addr  = 16'h0000;
        step();
        req_addr = 16'h0001;
        chk("b2b_a0", rom_addr, 16'h0000);
        step(5);
        chk("b2b_hold", rom_addr, 16'h0000);
        step();
        chk("b2b_d0_vld", rsp_valid, 1);
        chk("b2b_d0", rsp_data, 16'h0001);
        step();
        chk("b2b_gap_ce", ce_n, 1);
        chk("b2b_gap_vld", rsp_valid, 0);
        step();
        req_valid = 1'b0;
        chk("b2b_a1", rom_addr, 16'h0001);
        chk("b2b_a1_ce", ce_n, 0);
        step(6);
        chk("b2b_d1_vld", rsp_valid, 1);
        chk("b2b_d1", rsp_data, 16'h0002);
        step();
        chk("b2b_idle", busy, 0);

        // Flush at cnt==3
        req_valid = 1'b1;
        req_addr  = 16'h0010;
        step();
        req_valid = 1'b0;
        step(2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl3_ce_n", ce_n, 1);
        chk("fl3_oe_n", oe_n, 1);
        chk("fl3_busy", busy, 0);
        chk("fl3_vld", rsp_valid, 0);
        step(8);
        chk("fl3_late_vld", rsp_valid, 0);

        // Flush coincident with cnt==6
        req_valid = 1'b1;
        req_addr  = 16'h0010;
        step();
        req_valid = 1'b0;
        step(5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl6_vld", rsp_valid, 0);
        chk("fl6_busy", busy, 0);
        chk("fl6_data", rsp_data, 16'h0002);
        chk("fl6_ce_n", ce_n, 1);

        // Flush in RESP ignores rsp_ready=0
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'h0010;
        step();
        req_valid = 1'b0;
        step(6);
        chk("flr_vld", rsp_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flr_vld_clr", rsp_valid, 0);
        chk("flr_busy", busy, 0);
        chk("flr_data", rsp_data, 16'hBEEF);
        rsp_ready = 1'b1;

        // Flush in IDLE blocks a simultaneous request
        req_valid = 1'b1;
        req_addr  = 16'h0001;
        flush     = 1'b1;
        step();
        chk("fli_busy", busy, 0);
        chk("fli_ce_n", ce_n, 1);
        flush = 1'b0;
        step();
        req_valid = 1'b0;
        chk("fli_acc", busy, 1);

        // Async reset mid-ACCESS
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ce_n", ce_n, 1);
        chk("ar_vld", rsp_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_addr", rom_addr, 16'h0000);
        #1 rst_n = 1'b1;
        req_valid = 1'b1;
        req_addr  = 16'h0010;
        step();
        req_valid = 1'b0;
        chk("ar_e0_ce", ce_n, 0);
        step(5);
        chk("ar_e5_vld", rsp_valid, 0);
        step();
        chk("ar_vld6", rsp_valid, 1);
        chk("ar_data6", rsp_data, 16'hBEEF);
        step();
        chk("ar_done", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rom_fetch_ctrl.md
ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 6, meaning clock edges from ce_n falling to sampling of rom_dout (legal range 6..15).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  requester presents a fetch address.
REQ-005 SHALL have port req_addr  input  16  fetch address.
REQ-006 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 SHALL have port rsp_valid  output  1  rsp_data holds a fetched word.
REQ-008 SHALL have port rsp_data  output  16  fetched word.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts rsp_data this cycle.
REQ-010 SHALL have port flush  input  1  abort any in-flight or pending fetch.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port ce_n  output  1  ROM chip enable, active-low, registered.
REQ-013 SHALL have port oe_n  output  1  ROM output enable, active-low, registered.
REQ-014 SHALL have port rom_addr  output  16  ROM address, registered.
REQ-015 SHALL have port rom_dout  input  16  ROM data; ROM loads it on the 5th rising edge after it first samples ce_n=oe_n=0, and clears its internal counter whenever it samples either high.

Function
REQ-016 SHALL implement states IDLE, ACCESS, RESP with a 4-bit wait counter cnt.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid & req_ready & !flush.
REQ-018 On acceptance SHALL register rom_addr<=req_addr, ce_n<=0, oe_n<=0, cnt<=1, state<=ACCESS.
REQ-019 In ACCESS SHALL hold rom_addr, ce_n, oe_n stable and increment cnt each edge; req_addr changes are ignored.
REQ-020 On the edge where ACCESS is active and cnt==ACCESS_CYCLES SHALL capture rsp_data<=rom_dout, set rsp_valid<=1, ce_n<=1, oe_n<=1, cnt<=0, state<=RESP.
REQ-021 With ACCESS_CYCLES=6, capture SHALL occur on the 6th edge after the edge that drove ce_n low (one edge after the ROM loads rom_dout).
REQ-022 In RESP SHALL hold rsp_data and rsp_valid until an edge with rsp_ready=1, then rsp_valid<=0, state<=IDLE.
REQ-023 ce_n and oe_n SHALL be high for at least one full cycle between any two accesses (guaranteed by RESP and IDLE), so the ROM counter restarts at 0.
REQ-024 flush in ACCESS SHALL, on that edge, set ce_n<=1, oe_n<=1, cnt<=0, state<=IDLE, with no response produced, even if cnt==ACCESS_CYCLES.
REQ-025 flush in RESP SHALL clear rsp_valid and return to IDLE regardless of rsp_ready.
REQ-026 flush in IDLE SHALL block acceptance of a simultaneous req_valid.
REQ-027 rsp_data SHALL retain its last captured value after handshake or flush; only rsp_valid qualifies it.
REQ-028 busy SHALL equal (state!=IDLE), combinational from state.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, cnt=0, ce_n=1, oe_n=1, rom_addr=16'h0000, rsp_valid=0, rsp_data=16'h0000, regardless of clk.
REQ-030 After reset, req_ready SHALL be 1 and busy 0.
REQ-031 Reset asserted mid-ACCESS SHALL abandon the fetch with no response; first access after release follows REQ-018 normally.

Verification
REQ-032 Single fetch: ROM[16'h0010]=16'hBEEF, req addr 16'h0010 at edge E0 -> ce_n low after E0, rsp_valid=1 and rsp_data=16'hBEEF after E6, ce_n high after E6.
REQ-033 Back-pressure: rsp_ready=0 for 10 cycles after REQ-032 capture -> rsp_valid and 16'hBEEF held, ce_n stays 1, req_ready stays 0; rsp_ready=1 -> IDLE next edge.
REQ-034 Back-to-back: two requests 16'h0000 (16'h0001) and 16'h0001 (16'h0001 + ...) with rsp_ready=1 -> both words returned in order, ce_n high at least 1 cycle between accesses, ROM sees count restart each time.
REQ-035 Flush: flush at cnt==3 of ACCESS -> ce_n/oe_n high next edge, no rsp_valid, state IDLE; flush coincident with cnt==6 -> no capture.
REQ-036 Async reset: rst_n low between edges during ACCESS -> ce_n=1, rsp_valid=0 before next edge; subsequent fetch of 16'h0010 returns 16'hBEEF after 6 edges.
